// File: rtl/rv_pc_pkg.sv
// Shared types for the PC sequencer: FSM states, target-select encoding and fetch width.
// HALT is only part of the state set when PC_MISALIGN_TRAP_EN is defined.
package rv_pc_pkg;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

`ifdef PC_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        WAIT_EXEC = 2'd1,
        HALT      = 2'd2
    } pc_state_t;
`else
    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        WAIT_EXEC = 2'd1
    } pc_state_t;
`endif

    typedef enum logic [1:0] {
        TGT_SEQ = 2'd0,
        TGT_REL = 2'd1,
        TGT_JR  = 2'd2
    } tgt_sel_t;

    // JALR outranks JAL/B; a taken flag without any class flag falls back to sequential.
    function automatic tgt_sel_t select_target(
        input logic branch_taken,
        input logic is_b,
        input logic is_j,
        input logic is_jr
    );
        tgt_sel_t sel;
        sel = TGT_SEQ;
        if (is_jr && branch_taken) begin
            sel = TGT_JR;
        end else if ((is_j || is_b) && branch_taken) begin
            sel = TGT_REL;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC target, redirect flag and misalignment detection.
module pc_target_calc
    import rv_pc_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] src1,
    input  logic [31:0] imm,
    input  logic        branch_reg,
    input  logic        is_b_instr,
    input  logic        is_j_instr,
    input  logic        is_jr_instr,
    output logic [31:0] target,
    output logic        redirect,
    output logic        misaligned
);

    tgt_sel_t    sel;
    logic [31:0] jr_sum;

    always_comb begin
        sel    = select_target(branch_reg, is_b_instr, is_j_instr, is_jr_instr);
        jr_sum = src1 + imm;
        target = pc + INSTR_BYTES;
        case (sel)
            TGT_JR:  target = jr_sum & ~32'h1;
            TGT_REL: target = pc + imm;
            default: target = pc + INSTR_BYTES;
        endcase
        // Redirect follows the selection, not the value: a taken branch to pc+4 still counts.
        redirect   = (sel != TGT_SEQ);
        misaligned = |target[1:0];
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch handshake, PC/link update and redirect pulse.
// Define PC_MISALIGN_TRAP_EN to trap and halt on misaligned committed targets.
module pc_sequencer
    import rv_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_upd_en,
    input  logic        branch_reg,
    input  logic        is_b_instr,
    input  logic        is_j_instr,
    input  logic        is_jr_instr,
    input  logic [31:0] src1,
    input  logic [31:0] imm,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ack,
    output logic        fetch_done,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    output logic        redirect,
    output logic        trap,
    output logic [31:0] trap_addr
);

    pc_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] link_q, link_d;
    logic        fetch_done_q, fetch_done_d;
    logic        redirect_q, redirect_d;

    logic [31:0] calc_target;
    logic        calc_redirect;
    logic        calc_misaligned;

    pc_target_calc u_target_calc (
        .pc          (pc_q),
        .src1        (src1),
        .imm         (imm),
        .branch_reg  (branch_reg),
        .is_b_instr  (is_b_instr),
        .is_j_instr  (is_j_instr),
        .is_jr_instr (is_jr_instr),
        .target      (calc_target),
        .redirect    (calc_redirect),
        .misaligned  (calc_misaligned)
    );

`ifdef PC_MISALIGN_TRAP_EN
    logic        trap_q, trap_d;
    logic [31:0] trap_addr_q, trap_addr_d;
`else
    logic        unused_misaligned;
    assign unused_misaligned = calc_misaligned;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        link_d       = link_q;
        fetch_done_d = 1'b0;
        redirect_d   = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        trap_d       = 1'b0;
        trap_addr_d  = trap_addr_q;
`endif
        case (state_q)
            FETCH: begin
                if (fetch_ack) begin
                    fetch_done_d = 1'b1;
                    state_d      = WAIT_EXEC;
                end
            end
            WAIT_EXEC: begin
                if (pc_upd_en) begin
`ifdef PC_MISALIGN_TRAP_EN
                    // A misaligned target is never committed; pc and link keep their old values.
                    if (calc_misaligned) begin
                        trap_d      = 1'b1;
                        trap_addr_d = calc_target;
                        state_d     = HALT;
                    end else begin
                        pc_d       = calc_target;
                        link_d     = pc_q + INSTR_BYTES;
                        redirect_d = calc_redirect;
                        state_d    = FETCH;
                    end
`else
                    pc_d       = calc_target;
                    link_d     = pc_q + INSTR_BYTES;
                    redirect_d = calc_redirect;
                    state_d    = FETCH;
`endif
                end
            end
`ifdef PC_MISALIGN_TRAP_EN
            HALT: begin
                state_d = HALT;
            end
`endif
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            link_q       <= 32'h0;
            fetch_done_q <= 1'b0;
            redirect_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            link_q       <= link_d;
            fetch_done_q <= fetch_done_d;
            redirect_q   <= redirect_d;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_q      <= 1'b0;
            trap_addr_q <= 32'h0;
        end else begin
            trap_q      <= trap_d;
            trap_addr_q <= trap_addr_d;
        end
    end

    assign trap      = trap_q;
    assign trap_addr = trap_addr_q;
`else
    assign trap      = 1'b0;
    assign trap_addr = 32'h0;
`endif

    assign fetch_req  = (state_q == FETCH);
    assign fetch_addr = pc_q;
    assign fetch_done = fetch_done_q;
    assign pc         = pc_q;
    assign link_addr  = link_q;
    assign redirect   = redirect_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: expected PC/link/redirect/trap results are
// queued when a PC update is issued and compared when the DUT commits it.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_upd_en = 1'b0;
    logic        branch_reg = 1'b0;
    logic        is_b_instr = 1'b0;
    logic        is_j_instr = 1'b0;
    logic        is_jr_instr = 1'b0;
    logic [31:0] src1 = 32'h0;
    logic [31:0] imm = 32'h0;
    logic        fetch_ack = 1'b0;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_done;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        redirect;
    logic        trap;
    logic [31:0] trap_addr;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] link;
        logic        redirect;
        logic        trap;
        logic [31:0] trap_addr;
        logic        halted;
    } exp_t;

    exp_t        sb[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] model_pc = RST_PC;
    logic [31:0] model_link = 32'h0;
    logic        model_halted = 1'b0;

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_upd_en   (pc_upd_en),
        .branch_reg  (branch_reg),
        .is_b_instr  (is_b_instr),
        .is_j_instr  (is_j_instr),
        .is_jr_instr (is_jr_instr),
        .src1        (src1),
        .imm         (imm),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ack   (fetch_ack),
        .fetch_done  (fetch_done),
        .pc          (pc),
        .link_addr   (link_addr),
        .redirect    (redirect),
        .trap        (trap),
        .trap_addr   (trap_addr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Complete one fetch handshake with an ack in the first request cycle.
    task automatic fetchInstr(input string tag);
        checkOutput({tag, ".req"}, {31'h0, fetch_req}, 32'h1);
        checkOutput({tag, ".addr"}, fetch_addr, model_pc);
        fetch_ack = 1'b1;
        @(negedge clk);
        fetch_ack = 1'b0;
        checkOutput({tag, ".done"}, {31'h0, fetch_done}, 32'h1);
        checkOutput({tag, ".req_off"}, {31'h0, fetch_req}, 32'h0);
    endtask

    task automatic applyStimulus(input string tag, input logic br, input logic b, input logic j,
                                 input logic jr, input logic [31:0] s1, input logic [31:0] im);
        exp_t        e;
        exp_t        got;
        logic [31:0] tgt;
        logic        redir;
        if (jr && br) begin
            tgt   = (s1 + im) & 32'hFFFF_FFFE;
            redir = 1'b1;
        end else if ((j || b) && br) begin
            tgt   = model_pc + im;
            redir = 1'b1;
        end else begin
            tgt   = model_pc + 32'd4;
            redir = 1'b0;
        end
        e.tag = tag;
        e.trap = 1'b0;
        e.trap_addr = 32'h0;
        e.halted = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        if (tgt[1:0] != 2'b00) begin
            e.pc = model_pc;
            e.link = model_link;
            e.redirect = 1'b0;
            e.trap = 1'b1;
            e.trap_addr = tgt;
            e.halted = 1'b1;
        end else begin
            e.pc = tgt;
            e.link = model_pc + 32'd4;
            e.redirect = redir;
        end
`else
        e.pc = tgt;
        e.link = model_pc + 32'd4;
        e.redirect = redir;
`endif
        sb.push_back(e);
        pc_upd_en = 1'b1;
        branch_reg = br;
        is_b_instr = b;
        is_j_instr = j;
        is_jr_instr = jr;
        src1 = s1;
        imm = im;
        @(negedge clk);
        pc_upd_en = 1'b0;
        branch_reg = 1'b0;
        is_b_instr = 1'b0;
        is_j_instr = 1'b0;
        is_jr_instr = 1'b0;
        got = sb.pop_front();
        checkOutput({got.tag, ".pc"}, pc, got.pc);
        checkOutput({got.tag, ".link"}, link_addr, got.link);
        checkOutput({got.tag, ".redirect"}, {31'h0, redirect}, {31'h0, got.redirect});
        checkOutput({got.tag, ".trap"}, {31'h0, trap}, {31'h0, got.trap});
        checkOutput({got.tag, ".trap_addr"}, trap_addr, got.trap_addr);
        checkOutput({got.tag, ".req"}, {31'h0, fetch_req}, {31'h0, ~got.halted});
        checkOutput({got.tag, ".done"}, {31'h0, fetch_done}, 32'h0);
        model_pc = got.pc;
        model_link = got.link;
        model_halted = got.halted;
        @(negedge clk);
        checkOutput({got.tag, ".redirect_end"}, {31'h0, redirect}, 32'h0);
        checkOutput({got.tag, ".trap_end"}, {31'h0, trap}, 32'h0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_pc = RST_PC;
        model_link = 32'h0;
        model_halted = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        doReset();
        checkOutput("rst.pc", pc, RST_PC);
        checkOutput("rst.link", link_addr, 32'h0);
        checkOutput("rst.req", {31'h0, fetch_req}, 32'h1);
        checkOutput("rst.done", {31'h0, fetch_done}, 32'h0);
        checkOutput("rst.redirect", {31'h0, redirect}, 32'h0);
        checkOutput("rst.trap", {31'h0, trap}, 32'h0);
        checkOutput("rst.trap_addr", trap_addr, 32'h0);

        pc_upd_en = 1'b1;
        branch_reg = 1'b1;
        is_j_instr = 1'b1;
        imm = 32'h40;
        @(negedge clk);
        pc_upd_en = 1'b0;
        branch_reg = 1'b0;
        is_j_instr = 1'b0;
        checkOutput("upd_in_fetch.pc", pc, RST_PC);
        checkOutput("upd_in_fetch.req", {31'h0, fetch_req}, 32'h1);
        checkOutput("upd_in_fetch.redirect", {31'h0, redirect}, 32'h0);

        fetchInstr("f0");
        applyStimulus("seq", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        fetchInstr("f1");
        applyStimulus("jal", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_00FC);
        fetchInstr("f2");
        applyStimulus("b_taken", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFF8);
        fetchInstr("f3");
        applyStimulus("b_not_taken", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFF8);
        fetchInstr("f4");
        applyStimulus("br_no_class", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0040);
        fetchInstr("f5");
        applyStimulus("b_to_pc4", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h4);
        fetchInstr("f6");
        applyStimulus("jal_not_taken", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h80);
        fetchInstr("f7");
        applyStimulus("jalr_top", 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'hC);
        fetchInstr("f8");
        applyStimulus("wrap", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        fetchInstr("f9");
        applyStimulus("jr_over_j", 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h10);

        fetchInstr("f10");
        doReset();
        checkOutput("rst_wait.pc", pc, RST_PC);
        checkOutput("rst_wait.link", link_addr, 32'h0);
        checkOutput("rst_wait.req", {31'h0, fetch_req}, 32'h1);

        fetchInstr("f11");
        applyStimulus("seq2", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        doReset();
        checkOutput("rst_fetch.addr", fetch_addr, RST_PC);
        checkOutput("rst_fetch.req", {31'h0, fetch_req}, 32'h1);

        fetchInstr("f12");
        applyStimulus("jalr_odd", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_1003, 32'h4);
`ifdef PC_MISALIGN_TRAP_EN
        pc_upd_en = 1'b1;
        branch_reg = 1'b1;
        is_j_instr = 1'b1;
        imm = 32'h8;
        fetch_ack = 1'b1;
        @(negedge clk);
        pc_upd_en = 1'b0;
        branch_reg = 1'b0;
        is_j_instr = 1'b0;
        fetch_ack = 1'b0;
        @(negedge clk);
        checkOutput("halt.pc", pc, model_pc);
        checkOutput("halt.req", {31'h0, fetch_req}, 32'h0);
        checkOutput("halt.done", {31'h0, fetch_done}, 32'h0);
        checkOutput("halt.trap_addr", trap_addr, 32'h0000_1006);
        doReset();
        checkOutput("halt_rst.pc", pc, RST_PC);
        checkOutput("halt_rst.req", {31'h0, fetch_req}, 32'h1);
        checkOutput("halt_rst.trap_addr", trap_addr, 32'h0);
`else
        fetchInstr("f13");
        applyStimulus("after_odd", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the multicycle core; consumes the registered branch decision and instruction-class flags from the branch-condition stage and produces the next PC, the link address, and the instruction-fetch request. It sits between the control FSM, the execute stage (branch flag, rs1, immediate) and the instruction-memory port, closing the fetch → execute → PC-update loop.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- clk  in  1  core clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- pc_upd_en  in  1  one-cycle strobe from control FSM: commit next PC for the current instruction.
- branch_reg  in  1  registered branch/jump-taken flag from execute stage.
- is_b_instr / is_j_instr / is_jr_instr  in  1 each  instruction class (B-type, JAL, JALR).
- src1  in  32  rs1 value (JALR base).
- imm  in  32  sign-extended immediate.
- fetch_req  out  1  instruction fetch request.
- fetch_addr  out  32  fetch address (equals pc).
- fetch_ack  in  1  memory accepts/returns the instruction.
- fetch_done  out  1  one-cycle pulse: instruction available, execute may start.
- pc  out  32  current PC.
- link_addr  out  32  old PC + 4, for rd writeback of JAL/JALR.
- redirect  out  1  one-cycle pulse: non-sequential PC committed.
- trap  out  1  misaligned-target trap (only with PC_MISALIGN_TRAP_EN; else tied 0).
- trap_addr  out  32  offending target (0 without the macro).

## Operation
- States: FETCH, WAIT_EXEC, HALT (HALT exists only with macro).
- FETCH: fetch_req=1, fetch_addr=pc. On fetch_ack sampled high → fetch_done pulse, go WAIT_EXEC.
- WAIT_EXEC: fetch_req=0. On pc_upd_en: compute target, load pc, load link_addr=pc+4, go FETCH.
- Target priority: is_jr_instr & branch_reg → (src1+imm) & ~32'h1; else (is_j_instr|is_b_instr) & branch_reg → pc+imm; else pc+4.
- redirect=1 for one cycle when a non-pc+4 target selected by the rule above, even if numerically equal to pc+4.
- Arithmetic 32-bit modulo 2^32; wrap silently (0xFFFF_FFFC + 4 → 0).
- pc_upd_en in FETCH or HALT ignored; fetch_ack in WAIT_EXEC or HALT ignored.
- branch_reg with no class flag set → pc+4.
- Reset: pc=RESET_PC, link_addr=0, state=FETCH, fetch_done=0, redirect=0, trap=0, trap_addr=0; fetch_req=1 from first cycle after reset; reset mid-fetch abandons the outstanding request (memory sees address change to RESET_PC with req held).

## Timing
- pc, link_addr, redirect valid the cycle after pc_upd_en.
- fetch_req rises the cycle after pc update; min fetch = 1 cycle (ack in first req cycle → fetch_done next cycle).
- Control FSM guarantees pc_upd_en at least one cycle after the execute alu_en, so branch_reg is settled.
- Minimum instruction loop: 3 cycles (FETCH, WAIT_EXEC, pc_upd_en).

## Configuration
- PC_MISALIGN_TRAP_EN defined: committed target with bits[1:0]≠0 is not loaded; pc holds; trap pulses one cycle, trap_addr=target, state → HALT until rst. link_addr not updated.
- Undefined: targets loaded unchecked; trap=0, trap_addr=0; no HALT state.

## Structure
- Shared package rv_pc_pkg: state enum, INSTR_BYTES=4, target-select encoding.
- Sub-module pc_target_calc: combinational target, redirect and misalign computation; FSM and registers in pc_sequencer.

## Test plan
- Reset with RESET_PC=0x100 → pc=0x100, fetch_req=1 next cycle; ack → fetch_done pulse, fetch_req=0.
- Non-branch, pc=0x100, pc_upd_en → pc=0x104, link_addr=0x104, redirect=0.
- B taken, pc=0x200, imm=-8 → pc=0x1F8, redirect=1; same with branch_reg=0 → 0x204.
- JALR src1=0x1003, imm=4 → pc=0x1006 (bit0 cleared); with macro, target 0x1006 → trap=1, trap_addr=0x1006, pc held, HALT ignores pc_upd_en and fetch_ack.
- pc=0xFFFF_FFFC sequential → pc=0; pc_upd_en during FETCH ignored; rst asserted in WAIT_EXEC → pc=RESET_PC, FETCH next cycle.
